exe_unit_w2: RTL and testbench

//  Second-generation signed execution unit: width-parametrised, with a valid/ready

---
 rtl/exe_unit_w2.sv | 259 +++++++++++++++++++++++++
 tb/tb_exe_unit_w2.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_unit_w2.sv
`default_nettype none
// ============================================================================
// Module  : exe_unit_w2
// Purpose : Signed execution unit with a valid/ready request interface.
//           ADD, SUB and SHL (and illegal/divide-by-zero requests) complete in
//           one cycle. MUL, DIV and REM iterate M times over operand
//           magnitudes (shift-add multiply, restoring divide). The sign is
//           applied at the end. One operation is in flight at a time.
// Ports   : i_clk     rising-edge clock
//           i_rsn     asynchronous active-low reset
//           i_valid   request valid, sampled only while o_ready is high
//           o_ready   unit idle, request can be accepted
//           i_oper    opcode 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5 SHL
//           i_argA    signed operand A
//           i_argB    signed operand B (unsigned shift amount for SHL)
//           o_valid   one-cycle pulse, result/status issued
//           o_result  result, held until the next issue
//           o_status  {error, overflow, negative, zero}
// Revision: 1.0  initial release
// ============================================================================
module exe_unit_w2 #(
    parameter int M = 4,
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_oper,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    output logic         o_valid,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam int c_cw = $clog2(M + 1);

    localparam logic [N-1:0] c_op_add = N'(0);
    localparam logic [N-1:0] c_op_sub = N'(1);
    localparam logic [N-1:0] c_op_mul = N'(2);
    localparam logic [N-1:0] c_op_div = N'(3);
    localparam logic [N-1:0] c_op_rem = N'(4);
    localparam logic [N-1:0] c_op_shl = N'(5);

    typedef enum logic [1:0] {
        c_idle = 2'd0,
        c_busy = 2'd1,
        c_done = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic            r_ready;
    logic            r_valid;
    logic [M-1:0]    r_result;
    logic [3:0]      r_status;
    logic [N-1:0]    r_op;
    logic            r_neg_a;   // sign of A, gives the remainder sign
    logic            r_neg_q;   // sign of A xor sign of B, product/quotient sign
    logic [c_cw-1:0] r_cnt;
    logic [M-1:0]    r_opnd;    // multiplicand magnitude or divisor magnitude
    logic [2*M-1:0]  r_acc;     // {product high, multiplier} or {remainder, dividend/quotient}

    // ------------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the request inputs at acceptance
    // ------------------------------------------------------------------------
    logic [M-1:0]    w_mag_a;
    logic [M-1:0]    w_mag_b;
    logic [M-1:0]    w_sum;
    logic [M-1:0]    w_diff;
    logic [c_cw-1:0] w_sh_amt;
    logic [2*M-1:0]  w_sh_full;
    logic [M-1:0]    w_fast_res;
    logic            w_fast_ovf;
    logic            w_fast_err;
    logic            w_is_long;

    // MIN maps onto itself, which is the correct unsigned magnitude 2^(M-1)
    assign w_mag_a = i_argA[M-1] ? -i_argA : i_argA;
    assign w_mag_b = i_argB[M-1] ? -i_argB : i_argB;
    assign w_sum   = i_argA + i_argB;
    assign w_diff  = i_argA - i_argB;

    // Any amount >= M behaves like M: the low M bits are all zero and the
    // value is representable only when A is zero.
    assign w_sh_amt  = (32'(i_argB) >= M) ? c_cw'(M) : c_cw'(i_argB);
    assign w_sh_full = {{M{i_argA[M-1]}}, i_argA} << w_sh_amt;

    always_comb begin
        w_fast_res = '0;
        w_fast_ovf = 1'b0;
        w_fast_err = 1'b0;
        w_is_long  = 1'b0;
        case (i_oper)
            c_op_add: begin
                w_fast_res = w_sum;
                w_fast_ovf = (i_argA[M-1] == i_argB[M-1]) && (w_sum[M-1] != i_argA[M-1]);
            end
            c_op_sub: begin
                w_fast_res = w_diff;
                w_fast_ovf = (i_argA[M-1] != i_argB[M-1]) && (w_diff[M-1] != i_argA[M-1]);
            end
            c_op_mul: begin
                w_is_long = 1'b1;
            end
            c_op_div, c_op_rem: begin
                if (i_argB == '0) begin
                    w_fast_err = 1'b1;
                end else begin
                    w_is_long = 1'b1;
                end
            end
            c_op_shl: begin
                w_fast_res = w_sh_full[M-1:0];
                // Bits [2M-1:M-1] must all equal the sign for the value to fit
                w_fast_ovf = ~((&w_sh_full[2*M-1:M-1]) | ~(|w_sh_full[2*M-1:M-1]));
            end
            default: begin
                w_fast_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative datapath, one step per BUSY cycle
    // ------------------------------------------------------------------------
    logic [M:0]     w_mul_hi;
    logic [2*M-1:0] w_mul_next;
    logic [M:0]     w_rem_top;
    logic           w_trial_ge;
    logic [M-1:0]   w_rem_next;
    logic [2*M-1:0] w_div_next;
    logic [2*M-1:0] w_step_acc;

    // Shift-add multiply: add multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_hi   = {1'b0, r_acc[2*M-1:M]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_hi, r_acc[M-1:1]};

    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder stays below the
    // divisor, so the difference always fits in M bits.
    assign w_rem_top  = r_acc[2*M-1:M-1];
    assign w_trial_ge = (w_rem_top >= {1'b0, r_opnd});
    assign w_rem_next = w_rem_top[M-1:0] - r_opnd;
    assign w_div_next = {(w_trial_ge ? w_rem_next : w_rem_top[M-1:0]), r_acc[M-2:0], w_trial_ge};

    assign w_step_acc = (r_op == c_op_mul) ? w_mul_next : w_div_next;

    // Sign application on the value produced by the final step
    logic [2*M-1:0] w_prod_s;
    logic [M-1:0]   w_quo;
    logic [M-1:0]   w_quo_s;
    logic [M-1:0]   w_rmd;
    logic [M-1:0]   w_rmd_s;
    logic [M-1:0]   w_long_res;
    logic           w_long_ovf;

    assign w_prod_s = r_neg_q ? -w_step_acc : w_step_acc;
    assign w_quo    = w_step_acc[M-1:0];
    assign w_quo_s  = r_neg_q ? -w_quo : w_quo;
    assign w_rmd    = w_step_acc[2*M-1:M];
    assign w_rmd_s  = r_neg_a ? -w_rmd : w_rmd;

    always_comb begin
        w_long_res = w_rmd_s;
        w_long_ovf = 1'b0;
        if (r_op == c_op_mul) begin
            w_long_res = w_prod_s[M-1:0];
            w_long_ovf = ~((&w_prod_s[2*M-1:M-1]) | ~(|w_prod_s[2*M-1:M-1]));
        end else if (r_op == c_op_div) begin
            w_long_res = w_quo_s;
            // A positive quotient of magnitude 2^(M-1) (only MIN / -1) does not fit
            w_long_ovf = ~r_neg_q & w_quo[M-1];
        end
    end

    function automatic logic [3:0] f_status(input logic [M-1:0] res, input logic ovf, input logic err);
        return {err, ovf, res[M-1], (res == '0)};
    endfunction

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_state  <= c_idle;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_status <= '0;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_valid <= 1'b0;
                    if (i_valid && r_ready) begin
                        r_op    <= i_oper;
                        r_neg_a <= i_argA[M-1];
                        r_neg_q <= i_argA[M-1] ^ i_argB[M-1];
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        if (w_is_long) begin
                            r_state <= c_busy;
                            if (i_oper == c_op_mul) begin
                                r_opnd <= w_mag_a;
                                r_acc  <= {{M{1'b0}}, w_mag_b};
                            end else begin
                                r_opnd <= w_mag_b;
                                r_acc  <= {{M{1'b0}}, w_mag_a};
                            end
                        end else begin
                            r_state  <= c_done;
                            r_valid  <= 1'b1;
                            r_result <= w_fast_res;
                            r_status <= f_status(w_fast_res, w_fast_ovf, w_fast_err);
                        end
                    end
                end
                c_busy: begin
                    r_acc <= w_step_acc;
                    if (r_cnt == c_cw'(M - 1)) begin
                        r_state  <= c_done;
                        r_valid  <= 1'b1;
                        r_result <= w_long_res;
                        r_status <= f_status(w_long_res, w_long_ovf, 1'b0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= c_idle;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_exe_unit_w2.sv
`default_nettype none
// ============================================================================
// Module  : tb_exe_unit_w2
// Purpose : Self-checking bench for exe_unit_w2 (M=4, N=3). Directed cases
//           use hand-derived constants; random cases use an integer-arithmetic
//           reference model of the operations.
// Revision: 1.0  initial release
// ============================================================================
module tb_exe_unit_w2;

    localparam int c_m = 4;

    logic       i_clk;
    logic       i_rsn;
    logic       i_valid;
    logic       o_ready;
    logic [2:0] i_oper;
    logic [3:0] i_argA;
    logic [3:0] i_argB;
    logic       o_valid;
    logic [3:0] o_result;
    logic [3:0] o_status;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exe_unit_w2 #(.M(c_m), .N(3)) dut (
        .i_clk    (i_clk),
        .i_rsn    (i_rsn),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_oper   (i_oper),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_status (o_status)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference model: exact integer arithmetic, then range check and wrap
    task automatic model(input int op, input int au, input int bu,
                         output logic [3:0] res, output logic [3:0] st, output int lat);
        longint sa, sb, t, lo, hi;
        bit err, ovf;
        lo  = -(64'sd1 <<< (c_m - 1));
        hi  = (64'sd1 <<< (c_m - 1)) - 1;
        sa  = (au > hi) ? longint'(au) - (64'sd1 <<< c_m) : longint'(au);
        sb  = (bu > hi) ? longint'(bu) - (64'sd1 <<< c_m) : longint'(bu);
        t   = 0;
        err = 0;
        case (op)
            0: t = sa + sb;
            1: t = sa - sb;
            2: t = sa * sb;
            3: if (sb == 0) err = 1; else t = sa / sb;
            4: if (sb == 0) err = 1; else t = sa % sb;
            5: t = sa * (64'sd1 <<< bu);
            default: err = 1;
        endcase
        ovf = !err && (t < lo || t > hi);
        res = err ? 4'd0 : t[3:0];
        st  = {err, ovf, res[3], (res == 4'd0)};
        lat = (op == 2 || ((op == 3 || op == 4) && sb != 0)) ? c_m + 1 : 1;
    endtask

    // Issue one request (caller sits at a negedge) and wait for its result.
    // lat counts negedges from acceptance to o_valid; busy counts sampled
    // cycles before o_valid with o_ready low.
    task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] res, output logic [3:0] st,
                         output int lat, output int busy, output bit tmo);
        int guard = 0;
        i_oper  = op;
        i_argA  = a;
        i_argB  = b;
        i_valid = 1'b1;
        while (!o_ready && guard < 40) begin
            @(negedge i_clk);
            guard++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_oper  = 3'($urandom);
        i_argA  = 4'($urandom);
        i_argB  = 4'($urandom);
        lat  = 1;
        busy = 0;
        tmo  = 0;
        while (!o_valid && lat < 40) begin
            if (!o_ready) busy++;
            @(negedge i_clk);
            lat++;
        end
        if (!o_valid) tmo = 1;
        res = o_result;
        st  = o_status;
    endtask

    task automatic test_reset;
        i_rsn   = 1'b0;
        i_valid = 1'b0;
        i_oper  = 3'd0;
        i_argA  = 4'd0;
        i_argB  = 4'd0;
        repeat (3) @(negedge i_clk);
        i_rsn = 1'b1;
        @(negedge i_clk);
        total++;
        if ({o_ready, o_valid, o_result, o_status} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset_state: ready=%b valid=%b result=%b status=%b, want 1 0 0000 0000",
                     o_ready, o_valid, o_result, o_status);
        end
    endtask

    task automatic test_add;
        logic [3:0] r, s; int lat, busy; bit tmo;
        do_op(3'd0, 4'd7, 4'd3, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b1010 || s !== 4'b0110 || lat != 1) begin
            bad++;
            $display("FAIL add_7_3: result=%b status=%b lat=%0d, want 1010 0110 lat 1", r, s, lat);
        end
        @(negedge i_clk);
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 4'b1010 || o_status !== 4'b0110) begin
            bad++;
            $display("FAIL add_hold: valid=%b ready=%b result=%b status=%b, want 0 1 1010 0110",
                     o_valid, o_ready, o_result, o_status);
        end
    endtask

    task automatic test_mul;
        logic [3:0] r, s; int lat, busy; bit tmo;
        do_op(3'd2, 4'b1101, 4'd3, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b0111 || s !== 4'b0100 || lat != 5 || busy != 4) begin
            bad++;
            $display("FAIL mul_m3_3: result=%b status=%b lat=%0d busy=%0d, want 0111 0100 lat 5 busy 4",
                     r, s, lat, busy);
        end
        @(negedge i_clk);
        do_op(3'd2, 4'd3, 4'b1110, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b1010 || s !== 4'b0010 || lat != 5) begin
            bad++;
            $display("FAIL mul_3_m2: result=%b status=%b lat=%0d, want 1010 0010 lat 5", r, s, lat);
        end
        @(negedge i_clk);
    endtask

    task automatic test_div;
        logic [3:0] r, s; int lat, busy; bit tmo;
        do_op(3'd3, 4'b1001, 4'd2, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b1101 || s !== 4'b0010 || lat != 5) begin
            bad++;
            $display("FAIL div_m7_2: result=%b status=%b lat=%0d, want 1101 0010 lat 5", r, s, lat);
        end
        @(negedge i_clk);
        do_op(3'd4, 4'b1001, 4'd2, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b1111 || s !== 4'b0010 || lat != 5) begin
            bad++;
            $display("FAIL rem_m7_2: result=%b status=%b lat=%0d, want 1111 0010 lat 5", r, s, lat);
        end
        @(negedge i_clk);
        do_op(3'd3, 4'b1000, 4'b1111, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b1000 || s !== 4'b0110) begin
            bad++;
            $display("FAIL div_min_m1: result=%b status=%b, want 1000 0110", r, s);
        end
        @(negedge i_clk);
        do_op(3'd4, 4'b1000, 4'b1111, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b0000 || s !== 4'b0001) begin
            bad++;
            $display("FAIL rem_min_m1: result=%b status=%b, want 0000 0001", r, s);
        end
        @(negedge i_clk);
    endtask

    task automatic test_errors;
        logic [3:0] r, s; int lat, busy; bit tmo;
        do_op(3'd3, 4'd5, 4'd0, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b0000 || s !== 4'b1001 || lat != 1 || busy != 0) begin
            bad++;
            $display("FAIL div_by_zero: result=%b status=%b lat=%0d, want 0000 1001 lat 1", r, s, lat);
        end
        @(negedge i_clk);
        do_op(3'b110, 4'd5, 4'd3, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b0000 || s !== 4'b1001 || lat != 1) begin
            bad++;
            $display("FAIL illegal_op: result=%b status=%b lat=%0d, want 0000 1001 lat 1", r, s, lat);
        end
        @(negedge i_clk);
        do_op(3'd5, 4'b1111, 4'd4, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b0000 || s !== 4'b0101) begin
            bad++;
            $display("FAIL shl_m1_by_4: result=%b status=%b, want 0000 0101", r, s);
        end
        @(negedge i_clk);
    endtask

    // Request held valid with new operands while a MUL is busy
    task automatic test_busy_ignore;
        logic [3:0] res_q[$];
        logic [3:0] st_q[$];
        int at_q[$];
        i_oper  = 3'd2;
        i_argA  = 4'b1101;
        i_argB  = 4'd3;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_oper = 3'd0;
        i_argA = 4'd1;
        i_argB = 4'd2;
        for (int k = 1; k <= 20; k++) begin
            if (o_valid) begin
                res_q.push_back(o_result);
                st_q.push_back(o_status);
                at_q.push_back(k);
                if (res_q.size() == 2) begin
                    i_valid = 1'b0;
                    break;
                end
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        total++;
        if (res_q.size() != 2) begin
            bad++;
            $display("FAIL busy_ignore_count: pulses=%0d, want 2", res_q.size());
        end else begin
            total++;
            if (res_q[0] !== 4'b0111 || st_q[0] !== 4'b0100 || at_q[0] != 5) begin
                bad++;
                $display("FAIL busy_ignore_first: result=%b status=%b at=%0d, want 0111 0100 at 5",
                         res_q[0], st_q[0], at_q[0]);
            end
            total++;
            if (res_q[1] !== 4'b0011 || st_q[1] !== 4'b0000 || at_q[1] != 7) begin
                bad++;
                $display("FAIL busy_ignore_second: result=%b status=%b at=%0d, want 0011 0000 at 7",
                         res_q[1], st_q[1], at_q[1]);
            end
        end
        @(negedge i_clk);
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_extra: valid=%b, want 0", o_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] r, s; int lat, busy; bit tmo;
        int pulses = 0;
        do_op(3'd0, 4'd7, 4'd3, r, s, lat, busy, tmo);
        @(negedge i_clk);
        i_oper  = 3'd2;
        i_argA  = 4'd3;
        i_argB  = 4'd3;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rsn = 1'b0;
        #1;
        total++;
        if ({o_valid, o_result, o_status} !== 9'd0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_clear: valid=%b ready=%b result=%b status=%b, want 0 1 0000 0000",
                     o_valid, o_ready, o_result, o_status);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rsn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            if (o_valid) pulses++;
        end
        total++;
        if (pulses != 0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_drop: pulses=%0d ready=%b, want 0 1", pulses, o_ready);
        end
        do_op(3'd1, 4'd0, 4'd3, r, s, lat, busy, tmo);
        total++;
        if (tmo || r !== 4'b1101 || s !== 4'b0010 || lat != 1) begin
            bad++;
            $display("FAIL sub_0_3: result=%b status=%b lat=%0d, want 1101 0010 lat 1", r, s, lat);
        end
        @(negedge i_clk);
    endtask

    task automatic test_random;
        logic [3:0] r, s, er, es; int lat, busy, elat; bit tmo;
        logic [2:0] op; logic [3:0] a, b;
        for (int k = 0; k < 80; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom);
            b  = 4'($urandom);
            if ($urandom_range(0, 5) == 0) b = 4'd0;
            model(int'(op), int'(a), int'(b), er, es, elat);
            do_op(op, a, b, r, s, lat, busy, tmo);
            total++;
            if (tmo || r !== er || s !== es || lat != elat || busy != elat - 1) begin
                bad++;
                $display("FAIL random op=%0d a=%b b=%b: result=%b status=%b lat=%0d busy=%0d, want %b %b lat %0d busy %0d",
                         op, a, b, r, s, lat, busy, er, es, elat, elat - 1);
            end
            if ($urandom_range(0, 1) == 1) @(negedge i_clk);
        end
    endtask

    // Single-cycle ops issued with no idle gap: one result every 2 cycles
    task automatic test_back_to_back;
        logic [3:0] r, s, er, es; int lat, busy, elat; bit tmo;
        logic [2:0] op; logic [3:0] a, b;
        int last_cyc;
        int ops[3] = '{0, 1, 5};
        last_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            op = 3'(ops[$urandom_range(0, 2)]);
            a  = 4'($urandom);
            b  = 4'($urandom);
            model(int'(op), int'(a), int'(b), er, es, elat);
            do_op(op, a, b, r, s, lat, busy, tmo);
            total++;
            if (tmo || r !== er || s !== es || (last_cyc >= 0 && cyc - last_cyc != 2)) begin
                bad++;
                $display("FAIL back_to_back op=%0d a=%b b=%b: result=%b status=%b spacing=%0d, want %b %b spacing 2",
                         op, a, b, r, s, cyc - last_cyc, er, es);
            end
            last_cyc = cyc;
        end
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_errors();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
